// File: rtl/ltssm_substate_sequencer.sv
// Link-training substate sequencer: owns the current LTSSM substate, advances on agreed RX/TX exits,
// and falls back to Detect on watchdog expiry or disagreement, with bounded retries.
module ltssm_substate_sequencer #(
    parameter int unsigned           DEVICETYPE  = 0,
    parameter int unsigned           WD_WIDTH    = 24,
    parameter logic [WD_WIDTH-1:0]   WD_CYCLES   = 24'd1_000_000,
    parameter int unsigned           MAX_RETRIES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rxFinish,
    input  logic [3:0] rxExitTo,
    input  logic       txFinish,
    input  logic [3:0] txExitTo,
    output logic [3:0] substate,
    output logic       substateValid,
    output logic       forceDetect,
    output logic       linkUp,
    output logic       trainingError,
    output logic [2:0] retryCount
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_WAIT_RX = 3'd3,
        ST_WAIT_TX = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    localparam logic [3:0] SUB_L0        = 4'd10;
    localparam logic [3:0] INIT_SUBSTATE = (DEVICETYPE == 0) ? 4'd0 : 4'd0;
    localparam logic [3:0] MAX_R         = 4'(MAX_RETRIES);

    function automatic logic is_legal(input logic [3:0] s);
        return (s <= 4'd11);
    endfunction

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? 3'd7 : (v + 3'd1);
    endfunction

    state_t              state_q;
    logic [3:0]          substate_q;
    logic [3:0]          next_q;
    logic [3:0]          latch_q;
    logic [WD_WIDTH-1:0] wd_q;
    logic [2:0]          retry_q;
    logic                valid_q;
    logic                force_q;
    logic                link_q;
    logic                err_q;

    logic                pair_done_s;
    logic                pair_ok_s;
    logic [3:0]          cmp_a_s;
    logic [3:0]          cmp_b_s;
    logic                wd_expired_s;
    logic [2:0]          retry_inc_s;
    logic                retry_over_s;

    // Resolve which exitTo values are being compared this cycle and whether the pair agrees.
    always_comb begin
        pair_done_s = 1'b0;
        cmp_a_s     = rxExitTo;
        cmp_b_s     = txExitTo;
        case (state_q)
            ST_RUN: begin
                pair_done_s = rxFinish & txFinish;
            end
            ST_WAIT_TX: begin
                pair_done_s = txFinish;
                cmp_a_s     = rxFinish ? rxExitTo : latch_q;
            end
            ST_WAIT_RX: begin
                pair_done_s = rxFinish;
                cmp_b_s     = txFinish ? txExitTo : latch_q;
            end
            default: begin
                pair_done_s = 1'b0;
            end
        endcase
        pair_ok_s    = (cmp_a_s == cmp_b_s) && is_legal(cmp_a_s);
        wd_expired_s = (substate_q != SUB_L0) && (wd_q >= (WD_CYCLES - WD_WIDTH'(1)));
        retry_inc_s  = sat_inc3(retry_q);
        retry_over_s = ({1'b0, retry_inc_s} > MAX_R);
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            substate_q <= 4'd0;
            next_q     <= 4'd0;
            latch_q    <= 4'd0;
            wd_q       <= '0;
            retry_q    <= 3'd0;
            valid_q    <= 1'b0;
            force_q    <= 1'b0;
            link_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            force_q <= 1'b0;
            link_q  <= 1'b0;
            if (!start) begin
                state_q    <= ST_IDLE;
                substate_q <= 4'd0;
                latch_q    <= 4'd0;
                wd_q       <= '0;
                retry_q    <= 3'd0;
                err_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        next_q  <= INIT_SUBSTATE;
                        state_q <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        substate_q <= next_q;
                        valid_q    <= 1'b1;
                        wd_q       <= '0;
                        link_q     <= (next_q == SUB_L0);
                        if (next_q == SUB_L0) begin
                            retry_q <= 3'd0;
                        end
                        state_q <= ST_RUN;
                    end
                    ST_RUN, ST_WAIT_RX, ST_WAIT_TX: begin
                        if ((substate_q != SUB_L0) && (wd_q != '1)) begin
                            wd_q <= wd_q + WD_WIDTH'(1);
                        end
                        // A finish in this cycle always takes precedence over watchdog expiry.
                        if (pair_done_s && pair_ok_s) begin
                            next_q  <= cmp_a_s;
                            state_q <= ST_LOAD;
                        end else if (pair_done_s || (!rxFinish && !txFinish && wd_expired_s)) begin
                            force_q <= 1'b1;
                            retry_q <= retry_inc_s;
                            if (retry_over_s) begin
                                err_q      <= 1'b1;
                                substate_q <= 4'd0;
                                state_q    <= ST_ERROR;
                            end else begin
                                next_q  <= 4'd0;
                                state_q <= ST_LOAD;
                            end
                        end else if (rxFinish) begin
                            latch_q <= rxExitTo;
                            state_q <= ST_WAIT_TX;
                        end else if (txFinish) begin
                            latch_q <= txExitTo;
                            state_q <= ST_WAIT_RX;
                        end else begin
                            link_q <= (state_q == ST_RUN) && (substate_q == SUB_L0);
                        end
                    end
                    ST_ERROR: begin
                        err_q      <= 1'b1;
                        substate_q <= 4'd0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign substate      = substate_q;
    assign substateValid = valid_q;
    assign forceDetect   = force_q;
    assign linkUp        = link_q;
    assign trainingError = err_q;
    assign retryCount    = retry_q;

endmodule
